issue_dispatch_ctrl: RTL

Dispatch controller placed between rename and the two-port, four-input issue queue. Each cycle it accepts a group of up to four renamed instructions and tracks issue-queue occupancy from insertions and issue-port fires. It inserts a group only when enough slots are free, and holds a stalled group in a one-entry skid register. It also sequences a flush, which clears occupancy and drops any held group.

---
 rtl/issue_dispatch_ctrl_if.sv | 35 +++
 rtl/issue_dispatch_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/issue_dispatch_ctrl_if.sv
// Dispatch-side bus between rename, the dispatch controller and the issue queue.
// Controller is the slave; rename/issue-queue side is the master.
interface issue_dispatch_ctrl_if #(
  parameter int unsigned SIZE    = 32,
  parameter int unsigned WIDTH_I = 35
);
  localparam int unsigned WIDTH_CNT = $clog2(SIZE) + 1;

  logic [WIDTH_I-1:0]   i_inst1;
  logic [WIDTH_I-1:0]   i_inst2;
  logic [WIDTH_I-1:0]   i_inst3;
  logic [WIDTH_I-1:0]   i_inst4;
  logic [3:0]           i_valid;
  logic                 o_ready;
  logic [WIDTH_I-1:0]   o_inst1;
  logic [WIDTH_I-1:0]   o_inst2;
  logic [WIDTH_I-1:0]   o_inst3;
  logic [WIDTH_I-1:0]   o_inst4;
  logic                 o_en;
  logic [1:0]           i_issue;
  logic                 i_flush;
  logic [WIDTH_CNT-1:0] o_count;
  logic                 o_full;
  logic                 o_empty;

  modport master (
    output i_inst1, i_inst2, i_inst3, i_inst4, i_valid, i_issue, i_flush,
    input  o_ready, o_inst1, o_inst2, o_inst3, o_inst4, o_en, o_count, o_full, o_empty
  );

  modport slave (
    input  i_inst1, i_inst2, i_inst3, i_inst4, i_valid, i_issue, i_flush,
    output o_ready, o_inst1, o_inst2, o_inst3, o_inst4, o_en, o_count, o_full, o_empty
  );
endinterface

// File: rtl/issue_dispatch_ctrl.sv
// Dispatch controller: gates rename groups into the issue queue by free slots,
// holds a stalled group in a skid register, sequences flush. Option: DISPATCH_COMPACT_EN.
module issue_dispatch_ctrl #(
  parameter int unsigned SIZE    = 32,
  parameter int unsigned WIDTH_I = 35
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  issue_dispatch_ctrl_if.slave bus
);
  localparam int unsigned WIDTH_CNT = $clog2(SIZE) + 1;
  localparam int unsigned WIDTH_SUM = WIDTH_CNT + 1;
  localparam int unsigned LANES     = 4;

  typedef enum logic [1:0] {PASS, HOLD, FLUSH} state_t;

  state_t               state_q, state_d;
  logic [WIDTH_CNT-1:0] count_q, count_d;
  logic                 full_q, empty_q;
  logic [WIDTH_I-1:0]   skid_inst_q [LANES];
  logic [3:0]           skid_valid_q;

  logic [WIDTH_I-1:0]   in_lane  [LANES];
  logic [WIDTH_I-1:0]   src_lane [LANES];
  logic [WIDTH_I-1:0]   out_lane [LANES];
  logic [3:0]           src_valid;
  logic [2:0]           n_pop, n_gate;
  logic [WIDTH_CNT-1:0] free;
  logic                 fits;
  logic                 en_c, ready_c, capture, clear_skid;
  logic [WIDTH_SUM-1:0] sum;
  logic [1:0]           dec;
`ifdef DISPATCH_COMPACT_EN
  logic [1:0]           slot;
`endif

  assign in_lane[0] = bus.i_inst1;
  assign in_lane[1] = bus.i_inst2;
  assign in_lane[2] = bus.i_inst3;
  assign in_lane[3] = bus.i_inst4;

  // Group under consideration: live lanes, or the held group while stalled.
  always_comb begin
    src_valid = (state_q == HOLD) ? skid_valid_q : bus.i_valid;
    for (int unsigned k = 0; k < LANES; k++) begin
      src_lane[k] = (state_q == HOLD) ? skid_inst_q[k] : in_lane[k];
    end
  end

  assign n_pop = 3'($countones(src_valid));
`ifdef DISPATCH_COMPACT_EN
  assign n_gate = n_pop;
`else
  assign n_gate = 3'd4;
`endif
  assign free = WIDTH_CNT'(SIZE) - count_q;
  assign fits = free >= WIDTH_CNT'(n_gate);

  // Lane shaping; invalid lanes always leave as zero words.
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      out_lane[k] = '0;
    end
`ifdef DISPATCH_COMPACT_EN
    slot = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (src_valid[k]) begin
        out_lane[slot] = src_lane[k];
        slot           = slot + 2'd1;
      end
    end
`else
    for (int unsigned k = 0; k < LANES; k++) begin
      out_lane[k] = src_valid[k] ? src_lane[k] : '0;
    end
`endif
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        out_lane[k] = '0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    en_c       = 1'b0;
    ready_c    = 1'b0;
    capture    = 1'b0;
    clear_skid = 1'b0;
    unique case (state_q)
      PASS: begin
        ready_c = 1'b1;
        if (|bus.i_valid) begin
          if (fits) begin
            en_c = 1'b1;
          end else begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (fits) begin
          en_c    = 1'b1;
          state_d = PASS;
        end
      end
      FLUSH: begin
        clear_skid = 1'b1;
        state_d    = PASS;
      end
      default: state_d = PASS;
    endcase
    if (bus.i_flush) begin
      state_d    = FLUSH;
      en_c       = 1'b0;
      ready_c    = 1'b0;
      capture    = 1'b0;
      clear_skid = 1'b1;
    end
    // Outputs show reset values as soon as reset asserts, not at the next edge.
    if (!i_rst_n) begin
      en_c    = 1'b0;
      ready_c = 1'b1;
      capture = 1'b0;
    end
  end

  // Occupancy: inserts add, issue fires subtract (saturating at zero).
  always_comb begin
    sum = WIDTH_SUM'(count_q) + WIDTH_SUM'(en_c ? n_pop : 3'd0);
    dec = 2'($countones(bus.i_issue));
    if (state_q == FLUSH) begin
      count_d = '0;
    end else if (bus.i_flush) begin
      count_d = count_q;
    end else if (sum < WIDTH_SUM'(dec)) begin
      count_d = '0;
    end else begin
      count_d = WIDTH_CNT'(sum - WIDTH_SUM'(dec));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= PASS;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= count_d > WIDTH_CNT'(SIZE - 4);
      empty_q <= count_d == '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      skid_valid_q <= '0;
      for (int unsigned k = 0; k < LANES; k++) skid_inst_q[k] <= '0;
    end else if (clear_skid) begin
      skid_valid_q <= '0;
      for (int unsigned k = 0; k < LANES; k++) skid_inst_q[k] <= '0;
    end else if (capture) begin
      skid_valid_q <= bus.i_valid;
      for (int unsigned k = 0; k < LANES; k++) skid_inst_q[k] <= in_lane[k];
    end
  end

  assign bus.o_ready = ready_c;
  assign bus.o_en    = en_c;
  assign bus.o_inst1 = out_lane[0];
  assign bus.o_inst2 = out_lane[1];
  assign bus.o_inst3 = out_lane[2];
  assign bus.o_inst4 = out_lane[3];
  assign bus.o_count = count_q;
  assign bus.o_full  = full_q;
  assign bus.o_empty = empty_q;

`ifndef SYNTHESIS
  always @(posedge i_clk) begin
    if (i_rst_n && state_q != FLUSH && !bus.i_flush) begin
      assert (!(count_q == '0 && |bus.i_issue))
        else $error("issue_dispatch_ctrl: issue fired with empty issue queue");
    end
  end
`endif
endmodule
